frame_upscale_rd: RTL
=====================

# frame_upscale_rd

Read-side counterpart of the frame decimator. It pops decimated pixels from the frame FIFO and replicates each pixel SCALE times horizontally and each line SCALE times vertically, so the stream is restored to full output resolution. It sits between the frame FIFO read port and the display timing generator. Vertical replication uses an internal one-line buffer.

## Interface
- OUT_COL, 1280: active pixels per output line (1280 with SCALE=2, 1920 with SCALE=3)
- SCALE, 2: replication factor; legal values 2 or 3
- DATA_W, 16: pixel width (RGB565)
- Img_pclk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- Out_vs  in  1  frame sync from the timing generator; active high
- Out_de  in  1  active-video enable from the timing generator
- fifo_empty  in  1  frame FIFO empty flag
- fifo_rd_data  in  DATA_W  FIFO read data; valid one cycle after fifo_rd_en (not show-ahead)
- fifo_rd_en  out  1  FIFO pop; combinational from the registered counters and Out_de
- Img_de  out  1  Out_de delayed 1 cycle
- Img_data  out  DATA_W  upscaled pixel; 0 when Img_de=0
- underflow  out  1  sticky flag, set when a pop is needed while fifo_empty=1

## Operation
- Counters:
  - x: 0..OUT_COL-1, advances on Out_de, cleared when Out_de=0.
  - phase_x: 0..SCALE-1, wraps; cleared with x.
  - src_x = x/SCALE, held as a separate counter that increments when phase_x wraps. No divider.
  - phase_y: 0..SCALE-1, advances on the Out_de falling edge and wraps to 0.
- Rising edge of Out_vs: phase_y←0 and underflow←0. This is the frame resync.
- Fetch line (phase_y=0):
  - When Out_de=1, phase_x=0, x<OUT_COL and fifo_empty=0, assert fifo_rd_en.
  - On the next cycle, fifo_rd_data goes to Img_data, is captured into the hold register, and is written to the line buffer at src_x.
  - For phase_x=1..SCALE-1, output the hold register.
- Repeat lines (phase_y≠0):
  - Never pop the FIFO.
  - When phase_x=0, read the line buffer at src_x; the registered data arrives the next cycle, goes to Img_data and loads the hold register.
  - For phase_x≠0, output the hold register.
- Underflow: a pop is required but fifo_empty=1.
  - No pop is issued.
  - The output pixel and the hold register take 0.
  - The line buffer entry is written 0.
  - underflow←1.
- Overlong line (x≥OUT_COL while Out_de=1): output 0, no pops, no buffer writes. The x counter saturates and does not wrap.
- Short line (Out_de falls early): phase_y still advances. Unread FIFO data stays queued for the next fetch line.

## Timing
- Latency is exactly 1 cycle from Out_de to Img_de/Img_data on every line type.
- Reset values:
  - fifo_rd_en=0, Img_de=0, Img_data=0, underflow=0.
  - All counters 0; hold register 0.
  - Line buffer contents are undefined.
- Reset mid-line: all counters restart. The next Out_de high is treated as a fetch line.
- Out_vs edge and Out_de falling edge in the same cycle: the resync wins, so phase_y=0.
- Per fetch line, exactly OUT_COL/SCALE pops when nothing underflows.
- Line buffer: OUT_COL/SCALE × DATA_W, one write port and one read port, 1-cycle registered read. A write and a read never target the same line.

## Structure
- Package frame_pkg:
  - SCALE legality check constant.
  - BLANK_PIXEL = 16'h0000.
  - Width function clog2(OUT_COL).
- Sub-module frame_line_ram: simple dual-port RAM with DEPTH and DATA_W parameters and a registered read. Infers BRAM.
- The top level holds the counters, the fetch/repeat select and the output register.

## Test plan
- SCALE=2, OUT_COL=8, FIFO preloaded 0x0001..0x0008, two lines -> both lines output 1,1,2,2,3,3,4,4; exactly 4 pops on line 0 and 0 pops on line 1; Img_de lags Out_de by 1 cycle.
- SCALE=3, OUT_COL=9, FIFO 0xA..0xF, six lines -> lines 0-2 output A,A,A,B,B,B,C,C,C; lines 3-5 output D..F each ×3; pops occur only on lines 0 and 3.
- Underflow: FIFO holds 2 of 4 needed words -> output 1,1,2,2,0,0,0,0; underflow=1; the repeat line matches; underflow clears on the next Out_vs rise.
- Out_de held 12 cycles with OUT_COL=8 -> last 4 pixels are 0; total pops = 4.
- Out_vs pulse after line 0 of a 2-line group -> the next line is a fetch line (pops occur) and does not repeat line 0.
- rst asserted mid-line -> next cycle fifo_rd_en=0, Img_de=0, Img_data=0; the next line fetches from the FIFO.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types, constants and helpers for the frame upscaler read path.
// No timing of its own; used at elaboration by the upscaler and line RAM.
// No flow control; constants and pure functions only.
package frame_pkg;

    // Replication factors the datapath supports
    localparam int SCALE_MIN = 2;
    localparam int SCALE_MAX = 3;

    // Pixel value driven outside active video, on underflow and past line end
    localparam logic [15:0] BLANK_PIXEL = 16'h0000;

    // Source of the pixel presented in the cycle after Out_de is sampled
    typedef enum logic [1:0] {
        PIX_BLANK = 2'd0,
        PIX_HOLD  = 2'd1,
        PIX_FIFO  = 2'd2,
        PIX_RAM   = 2'd3
    } pix_sel_e;

    // True when the replication factor is one the counters can handle
    function automatic bit scale_legal(input int s);
        return (s >= SCALE_MIN) && (s <= SCALE_MAX);
    endfunction

    // Bits needed to index 'value' entries; never less than 1
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/frame_line_ram.sv
// Simple dual-port line buffer, one write and one read port.
// Read data is registered: valid the cycle after rd_en_i.
// No backpressure; every enabled access completes in one cycle.
module frame_line_ram
    import frame_pkg::*;
#(
    parameter int  DEPTH  = 640,
    parameter int  DATA_W = 16,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Write port; contents have no reset so the array maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/frame_upscale_rd.sv
// Pops decimated pixels and replicates each SCALE times across and down.
// Latency: 1 cycle from Out_de to Img_de/Img_data on every line type.
// No stall path: FIFO empty on a needed pop blanks the pixel and sets underflow.
module frame_upscale_rd
    import frame_pkg::*;
#(
    parameter int OUT_COL = 1280,
    parameter int SCALE   = 2,
    parameter int DATA_W  = 16
) (
    input  logic              Img_pclk,
    input  logic              rst,
    input  logic              Out_vs,
    input  logic              Out_de,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              Img_de,
    output logic [DATA_W-1:0] Img_data,
    output logic              underflow
);

    // An illegal factor falls back to the smallest legal one
    localparam int SCL   = scale_legal(SCALE) ? SCALE : SCALE_MIN;
    localparam int DEPTH = OUT_COL / SCL;
    localparam int XW    = clog2(OUT_COL + 1);
    localparam int AW    = clog2(DEPTH);
    localparam int PW    = 2;

    localparam logic [XW-1:0]     X_END   = XW'(OUT_COL);
    localparam logic [PW-1:0]     PH_LAST = PW'(SCL - 1);
    localparam logic [DATA_W-1:0] BLANK   = DATA_W'(BLANK_PIXEL);

    // x saturates at OUT_COL, which marks the overlong tail of a line
    logic [XW-1:0]     x_q, x_d;
    logic [PW-1:0]     phx_q, phx_d;
    logic [AW-1:0]     src_q, src_d;
    logic [PW-1:0]     phy_q, phy_d;
    logic              de_q, de_d;
    logic              vs_q, vs_d;
    logic              uf_q, uf_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    pix_sel_e          sel_q, sel_d;
    logic              load_q, load_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;

    logic              active;
    logic              fetch_line;
    logic              first_phase;
    logic              need_pix;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] pix;

    assign active      = Out_de && (x_q < X_END);
    assign fetch_line  = (phy_q == '0);
    assign first_phase = (phx_q == '0);
    assign need_pix    = active && first_phase;

    // Pop only on the first replica of each source pixel of a fetch line
    assign fifo_rd_en  = !rst && need_pix && fetch_line && !fifo_empty;
    assign ram_rd_en   = need_pix && !fetch_line;

    // Select the pixel for this output cycle from the source chosen last cycle
    always_comb begin
        pix = BLANK;
        unique case (sel_q)
            PIX_BLANK: pix = BLANK;
            PIX_HOLD:  pix = hold_q;
            PIX_FIFO:  pix = fifo_rd_data;
            PIX_RAM:   pix = ram_rd_data;
        endcase
    end

    assign Img_de    = de_q;
    assign Img_data  = de_q ? pix : BLANK;
    assign underflow = uf_q;

    // Counter advance, fetch/repeat source selection and sticky underflow
    always_comb begin
        x_d       = x_q;
        phx_d     = phx_q;
        src_d     = src_q;
        phy_d     = phy_q;
        uf_d      = uf_q;
        de_d      = Out_de;
        vs_d      = Out_vs;
        hold_d    = load_q ? pix : hold_q;
        sel_d     = PIX_BLANK;
        load_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;

        if (Out_de) begin
            if (active) begin
                x_d = x_q + XW'(1);
                if (phx_q == PH_LAST) begin
                    phx_d = '0;
                    src_d = src_q + AW'(1);
                end else begin
                    phx_d = phx_q + PW'(1);
                end

                if (!first_phase) begin
                    sel_d = PIX_HOLD;
                end else if (!fetch_line) begin
                    sel_d  = PIX_RAM;
                    load_d = 1'b1;
                end else begin
                    // Fetch: the line buffer records whatever is shown, 0 on underflow
                    load_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = src_q;
                    if (fifo_empty) begin
                        sel_d = PIX_BLANK;
                        uf_d  = 1'b1;
                    end else begin
                        sel_d = PIX_FIFO;
                    end
                end
            end
        end else begin
            x_d   = '0;
            phx_d = '0;
            src_d = '0;
            // Line end steps the vertical phase, even on short lines
            if (de_q) begin
                phy_d = (phy_q == PH_LAST) ? '0 : phy_q + PW'(1);
            end
        end

        // Frame resync takes priority over a simultaneous line end
        if (Out_vs && !vs_q) begin
            phy_d = '0;
            uf_d  = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge Img_pclk) begin
        if (rst) begin
            x_q       <= '0;
            phx_q     <= '0;
            src_q     <= '0;
            phy_q     <= '0;
            de_q      <= 1'b0;
            vs_q      <= 1'b0;
            uf_q      <= 1'b0;
            hold_q    <= BLANK;
            sel_q     <= PIX_BLANK;
            load_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            x_q       <= x_d;
            phx_q     <= phx_d;
            src_q     <= src_d;
            phy_q     <= phy_d;
            de_q      <= de_d;
            vs_q      <= vs_d;
            uf_q      <= uf_d;
            hold_q    <= hold_d;
            sel_q     <= sel_d;
            load_q    <= load_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    frame_line_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_line_ram (
        .clk_i     (Img_pclk),
        .wr_en_i   (wr_en_q),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (pix),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (src_q),
        .rd_data_o (ram_rd_data)
    );

endmodule
